serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Bit-serial, parametrised adder/subtractor for the ALU datapath. It generalises the combinational 4-bit ripple full-adder chain to any WIDTH and adds a subtract mode, a signed-overflow flag and a start/busy/done handshake. It processes one bit per clock through a single full-adder cell, trading latency for area. Results are registered and held until the next accepted operation completes.

## Interface

Parameters:
- WIDTH, default 8: operand width in bits. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle pulse: result just updated
- s  output  WIDTH+1  result: s[WIDTH-1:0] is the sum/difference modulo 2^WIDTH; s[WIDTH] is carry-out (add) or borrow (subtract)
- overflow  output  1  two's-complement signed overflow of the last result

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a into shift register A.
  - It latches b XOR {WIDTH{mode}} into shift register B.
  - The carry flop is set to mode, the bit counter is cleared, and the latched mode is stored. Next state is RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each cycle computes bit = A[0]^B[0]^c and the new carry c' = A[0]&B[0] | (A[0]^B[0])&c.
  - The bit is shifted into the MSB of an internal result shift register. A and B shift right, and the counter increments.
  - The carry entering the last bit (counter = WIDTH-1) is saved for the overflow calculation.
  - After the WIDTH-th bit, the internal register is copied to s[WIDTH-1:0] and next state is DONE.
  - s[WIDTH] = c' (add) or ~c' (subtract).
  - overflow = saved MSB carry-in XOR c'.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start is ignored in RUN and DONE. No queueing; it must be re-asserted in IDLE.
- Operand inputs are don't-care except in the cycle start is accepted. Changing them mid-operation has no effect.
- s and overflow hold the previous result throughout RUN. They change only on the completion edge.
- Wrap-around is modulo 2^WIDTH in both modes. Carry and borrow are reported only in s[WIDTH].

## Timing

- Reset (asynchronous, any time, including mid-RUN):
  - State goes to IDLE; busy=0, done=0, s=0, overflow=0.
  - The counter and shift registers clear, and any operation in flight is discarded.
  - Deasserting reset produces no spurious done.
- start is accepted at edge E0.
  - busy=1 from E0 through edge E0+WIDTH.
  - The bits are processed on edges E0+1 … E0+WIDTH.
  - s and overflow are valid, and done=1, in the cycle following E0+WIDTH.
  - Latency from the accepting edge to a visible result is WIDTH+1 edges.
- busy and done are never high together.
- Minimum start-to-start spacing is WIDTH+2 cycles. A start held high continuously is accepted again in the first IDLE cycle after DONE.

## Test plan

- WIDTH=4, add: a=0101, b=1101 -> done after 5 edges, s=1_0010, overflow=0. Also 0001+0011 -> s=0_0100.
- WIDTH=4, add: a=1000, b=1000 -> s=1_0000, overflow=1. Then 0000+0000 -> s=0_0000, overflow=0.
- WIDTH=4, subtract: a=0011, b=0101 -> s=1_1110 (borrow), overflow=0. Also a=0111, b=1000 -> s=1_1111, overflow=1.
- WIDTH=4, start re-pulsed during RUN with other operands -> ignored; original result delivered; exactly one done pulse.
- WIDTH=4, reset asserted at bit 2 of an operation -> busy, done, s and overflow all 0 immediately. A new start after release gives the correct result with normal latency.
- WIDTH=16, add/subtract with 200 random operand pairs and start held high -> every result matches the a±b reference. Each done pulse arrives 17 edges after acceptance, and s is stable between done pulses.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master issues operations and the slave (the datapath) returns results.
`timescale 1ns/1ps
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   s;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, s, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, s, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full-adder cell, one operand bit per clock.
// Results are registered and held until the next accepted operation completes.
`timescale 1ns/1ps
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    serial_add_sub_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-2:0] res_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   s_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] b_cond;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    // Subtraction is a + ~b + 1: invert B here and seed the carry with mode.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_cond[gi] = bus.b[gi] ^ bus.mode;
        end
    endgenerate

    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | ((a_reg[0] ^ b_reg[0]) & carry_reg);
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
    assign res_next   = {sum_bit, res_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            mode_reg  <= 1'b0;
            cnt_reg   <= '0;
            s_reg     <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= b_cond;
                        carry_reg <= bus.mode;
                        mode_reg  <= bus.mode;
                        cnt_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_next;
                    res_reg   <= res_next[WIDTH-1:1];
                    cnt_reg   <= cnt_reg + 1'b1;
                    // On the MSB cycle carry_reg is the carry into the sign bit.
                    if (last_bit) begin
                        s_reg     <= {carry_next ^ mode_reg, res_next};
                        ovf_reg   <= carry_reg ^ carry_next;
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state_reg == RUN);
    assign bus.done     = (state_reg == DONE);
    assign bus.s        = s_reg;
    assign bus.overflow = ovf_reg;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub at WIDTH=4 and WIDTH=16 against an arithmetic model
// of a+/-b with a transaction-level timing model, checked every cycle.
`timescale 1ns/1ps
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic        mode_v  [2];
    logic [15:0] a_v     [2];
    logic [15:0] b_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        ovf_v   [2];
    logic [16:0] s_v     [2];

    int          wid      [2] = '{4, 16};
    int          phase    [2];
    logic [16:0] pend_s   [2];
    logic [16:0] exp_s    [2];
    logic        pend_o   [2];
    logic        exp_o    [2];
    int          done_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int W = (gi == 0) ? 4 : 16;
            serial_add_sub_if #(.WIDTH(W)) bus ();
            assign bus.start  = start_v[gi];
            assign bus.mode   = mode_v[gi];
            assign bus.a      = a_v[gi][W-1:0];
            assign bus.b      = b_v[gi][W-1:0];
            assign busy_v[gi] = bus.busy;
            assign done_v[gi] = bus.done;
            assign ovf_v[gi]  = bus.overflow;
            assign s_v[gi]    = 17'(bus.s);
            serial_add_sub #(.WIDTH(W)) u_dut (
                .clk   (clk),
                .reset (rst),
                .bus   (bus.slave)
            );
        end
    endgenerate

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^w with borrow/carry in bit w.
    function automatic void ref_op(input int w, input logic m, input logic [15:0] a,
                                   input logic [15:0] b, output logic [16:0] r, output logic o);
        longint mask = (longint'(1) << w) - 1;
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint res;
        longint sa, sb, sr;
        if (!m) res = ua + ub;
        else    res = ((ua - ub) & mask) | ((ua < ub) ? (longint'(1) << w) : longint'(0));
        sa = (ua >> (w - 1)) & 1;
        sb = (ub >> (w - 1)) & 1;
        sr = (res >> (w - 1)) & 1;
        o  = m ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        r  = 17'(res);
    endfunction

    // phase: 0 idle, 1..w bit edges after acceptance, w+1 result/done cycle.
    task automatic model_step(input int i);
        if (rst) begin
            phase[i] = 0;
            exp_s[i] = '0;
            exp_o[i] = 1'b0;
        end else if (phase[i] == 0) begin
            if (start_v[i]) begin
                ref_op(wid[i], mode_v[i], a_v[i], b_v[i], pend_s[i], pend_o[i]);
                phase[i] = 1;
            end
        end else if (phase[i] < wid[i]) begin
            phase[i]++;
        end else if (phase[i] == wid[i]) begin
            exp_s[i] = pend_s[i];
            exp_o[i] = pend_o[i];
            phase[i] = wid[i] + 1;
        end else begin
            phase[i] = 0;
        end
    endtask

    task automatic compare(input int i);
        logic eb, ed;
        eb = (phase[i] >= 1) && (phase[i] <= wid[i]);
        ed = (phase[i] == wid[i] + 1);
        chk($sformatf("w%0d_busy", wid[i]), longint'(busy_v[i]), longint'(eb));
        chk($sformatf("w%0d_done", wid[i]), longint'(done_v[i]), longint'(ed));
        chk($sformatf("w%0d_s", wid[i]), longint'(s_v[i]), longint'(exp_s[i]));
        chk($sformatf("w%0d_ovf", wid[i]), longint'(ovf_v[i]), longint'(exp_o[i]));
        if (done_v[i]) done_cnt[i]++;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 2; i++) compare(i);
    endtask

    task automatic do_op(input int i, input logic m, input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] lit_s, input logic lit_o);
        int  n;
        logic got;
        start_v[i] = 1'b1;
        mode_v[i]  = m;
        a_v[i]     = a;
        b_v[i]     = b;
        tick();
        start_v[i] = 1'b0;
        a_v[i]     = 16'($urandom);
        b_v[i]     = 16'($urandom);
        mode_v[i]  = ~m;
        n   = 0;
        got = 1'b0;
        while (n < wid[i] + 3 && !got) begin
            tick();
            n++;
            got = done_v[i];
        end
        $display("op w%0d mode=%0d a=%h b=%h -> s=%h ovf=%0d after %0d edges",
                 wid[i], m, a, b, s_v[i], ovf_v[i], n + 1);
        chk("op_latency", longint'(n), longint'(wid[i]));
        chk("op_literal_s", longint'(s_v[i]), longint'(lit_s));
        chk("op_literal_ovf", longint'(ovf_v[i]), longint'(lit_o));
        tick();
    endtask

    typedef struct {
        logic       m;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        logic       o;
    } vec_t;

    vec_t tbl [6] = '{
        '{1'b0, 4'b0101, 4'b1101, 5'b10010, 1'b0},
        '{1'b0, 4'b0001, 4'b0011, 5'b00100, 1'b0},
        '{1'b0, 4'b1000, 4'b1000, 5'b10000, 1'b1},
        '{1'b0, 4'b0000, 4'b0000, 5'b00000, 1'b0},
        '{1'b1, 4'b0011, 4'b0101, 5'b11110, 1'b0},
        '{1'b1, 4'b0111, 4'b1000, 5'b11111, 1'b1}
    };

    initial begin
        int base;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; mode_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
            phase[i] = 0; exp_s[i] = '0; exp_o[i] = 1'b0; done_cnt[i] = 0;
            pend_s[i] = '0; pend_o[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_busy", longint'(busy_v[0]), 0);
        chk("reset_done", longint'(done_v[0]), 0);
        chk("reset_s", longint'(s_v[0]), 0);
        chk("reset_ovf", longint'(ovf_v[0]), 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int k = 0; k < 6; k++)
            do_op(0, tbl[k].m, 16'(tbl[k].a), 16'(tbl[k].b), 17'(tbl[k].s), tbl[k].o);

        // Start re-pulsed mid-RUN with different operands must be ignored.
        start_v[0] = 1'b1; mode_v[0] = 1'b0; a_v[0] = 16'h2; b_v[0] = 16'h3;
        tick();
        start_v[0] = 1'b0;
        tick();
        base = done_cnt[0];
        start_v[0] = 1'b1; mode_v[0] = 1'b1; a_v[0] = 16'hf; b_v[0] = 16'hf;
        tick();
        start_v[0] = 1'b0;
        repeat (12) tick();
        $display("repulse: done pulses=%0d s=%h ovf=%0d", done_cnt[0] - base, s_v[0], ovf_v[0]);
        chk("repulse_done_count", longint'(done_cnt[0] - base), 1);
        chk("repulse_s", longint'(s_v[0]), longint'(17'b00101));
        chk("repulse_ovf", longint'(ovf_v[0]), 0);

        // Asynchronous reset in the middle of an operation.
        start_v[0] = 1'b1; mode_v[0] = 1'b1; a_v[0] = 16'h6; b_v[0] = 16'h1;
        tick();
        start_v[0] = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0; exp_s[i] = '0; exp_o[i] = 1'b0;
        end
        $display("midrun reset: busy=%0d done=%0d s=%h ovf=%0d", busy_v[0], done_v[0], s_v[0], ovf_v[0]);
        chk("midreset_busy", longint'(busy_v[0]), 0);
        chk("midreset_done", longint'(done_v[0]), 0);
        chk("midreset_s", longint'(s_v[0]), 0);
        chk("midreset_ovf", longint'(ovf_v[0]), 0);
        repeat (2) tick();
        rst = 1'b0;
        base = done_cnt[0];
        repeat (3) tick();
        chk("no_spurious_done", longint'(done_cnt[0] - base), 0);
        do_op(0, 1'b0, 16'h6, 16'h3, 17'b01001, 1'b1);

        // WIDTH=16 back-to-back with start held high and random operands.
        base = done_cnt[1];
        start_v[1] = 1'b1;
        for (int t = 0; t < 200 * 18 + 40 && (done_cnt[1] - base) < 200; t++) begin
            mode_v[1] = 1'($urandom_range(0, 1));
            a_v[1]    = 16'($urandom);
            b_v[1]    = 16'($urandom);
            tick();
        end
        start_v[1] = 1'b0;
        $display("w16 random: %0d results", done_cnt[1] - base);
        chk("w16_result_count", longint'(done_cnt[1] - base), 200);
        repeat (20) tick();

        do_op(1, 1'b0, 16'hffff, 16'h0001, 17'h10000, 1'b0);
        do_op(1, 1'b1, 16'h8000, 16'h0001, 17'h07fff, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
